// File: rtl/fifo_banco_vc.sv
// Four-lane input FIFO bank fed by the demux/recirculation stage.
// Each lane has its own FIFO, pop port, flags and sticky error; pause tells upstream to hold traffic.
module fifo_banco_vc #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  input  logic              pop_0,
  input  logic              pop_1,
  input  logic              pop_2,
  input  logic              pop_3,
  output logic [DATA_W-1:0] dataout_0,
  output logic [DATA_W-1:0] dataout_1,
  output logic [DATA_W-1:0] dataout_2,
  output logic [DATA_W-1:0] dataout_3,
  output logic              valid_out_0,
  output logic              valid_out_1,
  output logic              valid_out_2,
  output logic              valid_out_3,
  output logic              full_0,
  output logic              full_1,
  output logic              full_2,
  output logic              full_3,
  output logic              empty_0,
  output logic              empty_1,
  output logic              empty_2,
  output logic              empty_3,
  output logic              almost_full_0,
  output logic              almost_full_1,
  output logic              almost_full_2,
  output logic              almost_full_3,
  output logic              almost_empty_0,
  output logic              almost_empty_1,
  output logic              almost_empty_2,
  output logic              almost_empty_3,
  output logic              error_0,
  output logic              error_1,
  output logic              error_2,
  output logic              error_3,
  output logic              pause
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(ALMOST_FULL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(ALMOST_EMPTY);

  logic [3:0][DATA_W-1:0] din;
  logic [3:0][DATA_W-1:0] dout;
  logic [3:0] push_req, pop_req;
  logic [3:0] vout, full, empty, afull, aempty, err;

  assign din      = {data_3, data_2, data_1, data_0};
  assign push_req = {valid_3, valid_2, valid_1, valid_0};
  assign pop_req  = {pop_3, pop_2, pop_1, pop_0};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] dout_r;
    logic              vout_r, err_r;
    logic              push_ok, pop_ok, overflow, underflow;

    assign full[g]   = (count == DEPTH_C);
    assign empty[g]  = (count == '0);
    assign afull[g]  = (count >= AF_C);
    assign aempty[g] = (count <= AE_C);

    // A full lane still takes a push when the same cycle pops; an empty lane never bypasses write to read.
    assign pop_ok    = pop_req[g] & ~empty[g];
    assign push_ok   = push_req[g] & (~full[g] | pop_req[g]);
    assign overflow  = push_req[g] & full[g] & ~pop_req[g];
    assign underflow = pop_req[g] & empty[g];

    always_ff @(posedge clk_f) begin
      if (push_ok && !reset) mem[wr_ptr] <= din[g];
    end

    always_ff @(posedge clk_f) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        dout_r <= '0;
        vout_r <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          dout_r <= mem[rd_ptr];
        end
        vout_r <= pop_ok;
        count  <= count + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
        if (overflow || underflow) err_r <= 1'b1;
      end
    end

    assign dout[g] = dout_r;
    assign vout[g] = vout_r;
    assign err[g]  = err_r;
  end

  assign pause = |afull;

  assign dataout_0 = dout[0];
  assign dataout_1 = dout[1];
  assign dataout_2 = dout[2];
  assign dataout_3 = dout[3];
  assign {valid_out_3, valid_out_2, valid_out_1, valid_out_0}             = vout;
  assign {full_3, full_2, full_1, full_0}                                 = full;
  assign {empty_3, empty_2, empty_1, empty_0}                             = empty;
  assign {almost_full_3, almost_full_2, almost_full_1, almost_full_0}     = afull;
  assign {almost_empty_3, almost_empty_2, almost_empty_1, almost_empty_0} = aempty;
  assign {error_3, error_2, error_1, error_0}                             = err;

endmodule

// File: tb/tb_fifo_banco_vc.sv
// Self-checking bench for fifo_banco_vc: directed lane scenarios plus random traffic
// compared against a queue-based reference model of the four lanes.
module tb_fifo_banco_vc;

  logic       clk_f = 1'b0;
  logic       rst;
  logic [7:0] d_in [4];
  logic       v_in [4];
  logic       p_in [4];
  logic [7:0] dout_w [4];
  logic       vout_w [4], full_w [4], empty_w [4], af_w [4], ae_w [4], err_w [4];
  logic       pause_w;

  // reference model: one queue per lane plus last popped word and sticky error
  logic [7:0] q [4][$];
  logic [7:0] m_dout [4];
  logic       m_vout [4];
  logic       m_err [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_f = ~clk_f;

  fifo_banco_vc dut (
    .clk_f(clk_f), .reset(rst),
    .data_0(d_in[0]), .data_1(d_in[1]), .data_2(d_in[2]), .data_3(d_in[3]),
    .valid_0(v_in[0]), .valid_1(v_in[1]), .valid_2(v_in[2]), .valid_3(v_in[3]),
    .pop_0(p_in[0]), .pop_1(p_in[1]), .pop_2(p_in[2]), .pop_3(p_in[3]),
    .dataout_0(dout_w[0]), .dataout_1(dout_w[1]), .dataout_2(dout_w[2]), .dataout_3(dout_w[3]),
    .valid_out_0(vout_w[0]), .valid_out_1(vout_w[1]), .valid_out_2(vout_w[2]), .valid_out_3(vout_w[3]),
    .full_0(full_w[0]), .full_1(full_w[1]), .full_2(full_w[2]), .full_3(full_w[3]),
    .empty_0(empty_w[0]), .empty_1(empty_w[1]), .empty_2(empty_w[2]), .empty_3(empty_w[3]),
    .almost_full_0(af_w[0]), .almost_full_1(af_w[1]), .almost_full_2(af_w[2]), .almost_full_3(af_w[3]),
    .almost_empty_0(ae_w[0]), .almost_empty_1(ae_w[1]), .almost_empty_2(ae_w[2]), .almost_empty_3(ae_w[3]),
    .error_0(err_w[0]), .error_1(err_w[1]), .error_2(err_w[2]), .error_3(err_w[3]),
    .pause(pause_w)
  );

  task automatic clear_inputs();
    rst = 1'b0;
    for (int l = 0; l < 4; l++) begin
      d_in[l] = 8'h00;
      v_in[l] = 1'b0;
      p_in[l] = 1'b0;
    end
  endtask

  // one clock edge; the model advances on the same inputs, outputs are then sampled 1 time unit later
  task automatic tick();
    @(posedge clk_f);
    for (int l = 0; l < 4; l++) begin
      int n = q[l].size();
      bit pop_ok  = p_in[l] && (n > 0);
      bit push_ok = v_in[l] && ((n < 4) || p_in[l]);
      if (rst) begin
        q[l].delete();
        m_dout[l] = 8'h00;
        m_vout[l] = 1'b0;
        m_err[l]  = 1'b0;
      end else begin
        if ((v_in[l] && n == 4 && !p_in[l]) || (p_in[l] && n == 0)) m_err[l] = 1'b1;
        m_vout[l] = pop_ok;
        if (pop_ok) m_dout[l] = q[l].pop_front();
        if (push_ok) q[l].push_back(d_in[l]);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      if (s == 0) begin
        rst = 1'b1;
        for (int l = 0; l < 4; l++) begin
          v_in[l] = 1'b1;
          p_in[l] = 1'b1;
          d_in[l] = 8'($urandom);
        end
      end
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 5;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL reset lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL reset lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL reset lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL reset lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
        if (gf !== 4'b0101) begin n_fail++; $display("[TB] FAIL reset lane%0d idle flags got %b exp 0101", l, gf); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL reset pause got %b exp %b", pause_w, ep); end
    end
  endtask

  task automatic test_lane0_order();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
    for (int s = 0; s < 7; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      if (s < 3) begin v_in[0] = 1'b1; d_in[0] = vals[s]; end
      else if (s < 6) p_in[0] = 1'b1;
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL lane0_order lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL lane0_order lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL lane0_order lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL lane0_order lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL lane0_order pause got %b exp %b", pause_w, ep); end
      if (s == 2) begin
        n_chk++;
        if ({af_w[0], pause_w} !== 2'b11) begin n_fail++; $display("[TB] FAIL lane0_almost_full {af0,pause} got %b exp 11", {af_w[0], pause_w}); end
      end
      if (s >= 3 && s < 6) begin
        n_chk++;
        if (dout_w[0] !== vals[s-3] || vout_w[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL lane0_pop%0d dataout got %h/%b exp %h/1", s-3, dout_w[0], vout_w[0], vals[s-3]); end
      end
      if (s == 6) begin
        n_chk++;
        if (empty_w[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL lane0_drained empty got %b exp 1", empty_w[0]); end
      end
    end
  endtask

  task automatic test_lane1_overflow();
    for (int s = 0; s < 9; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      if (s < 5) begin v_in[1] = 1'b1; d_in[1] = 8'(8'h10 + s); end
      else p_in[1] = 1'b1;
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL lane1_ovf lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL lane1_ovf lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL lane1_ovf lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL lane1_ovf lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL lane1_ovf pause got %b exp %b", pause_w, ep); end
      if (s == 3 || s == 4) begin
        n_chk++;
        if ({full_w[1], err_w[1]} !== {1'b1, s == 4}) begin n_fail++; $display("[TB] FAIL lane1_full step%0d {full1,err1} got %b exp %b", s, {full_w[1], err_w[1]}, {1'b1, s == 4}); end
      end
      if (s >= 5) begin
        n_chk++;
        if (dout_w[1] !== 8'(8'h10 + s - 5)) begin n_fail++; $display("[TB] FAIL lane1_pop%0d dataout got %h exp %h", s-5, dout_w[1], 8'(8'h10 + s - 5)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 16; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      if (s < 4) begin v_in[2] = 1'b1; d_in[2] = 8'(8'h20 + s); end
      else if (s < 12) begin v_in[2] = 1'b1; p_in[2] = 1'b1; d_in[2] = 8'(8'h50 + s - 4); end
      else p_in[2] = 1'b1;
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL b2b lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL b2b lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL b2b lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL b2b lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL b2b pause got %b exp %b", pause_w, ep); end
      if (s >= 4 && s < 12) begin
        logic [7:0] exp_w = (s < 8) ? 8'(8'h20 + s - 4) : 8'(8'h50 + s - 8);
        n_chk++;
        if ({dout_w[2], full_w[2], err_w[2]} !== {exp_w, 2'b10}) begin n_fail++; $display("[TB] FAIL b2b_step%0d {dout2,full2,err2} got %h,%b,%b exp %h,1,0", s, dout_w[2], full_w[2], err_w[2], exp_w); end
      end
    end
  endtask

  task automatic test_lane3_underflow();
    for (int s = 0; s < 3; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      p_in[3] = 1'b1;
      if (s == 1) begin v_in[3] = 1'b1; d_in[3] = 8'h77; end
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL lane3_udf lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL lane3_udf lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL lane3_udf lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL lane3_udf lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL lane3_udf pause got %b exp %b", pause_w, ep); end
      n_chk++;
      case (s)
        0: if ({vout_w[3], err_w[3]} !== 2'b01) begin n_fail++; $display("[TB] FAIL lane3_empty_pop {vout3,err3} got %b exp 01", {vout_w[3], err_w[3]}); end
        1: if ({vout_w[3], empty_w[3], ae_w[3]} !== 3'b001) begin n_fail++; $display("[TB] FAIL lane3_push_pop_empty {vout3,empty3,ae3} got %b exp 001", {vout_w[3], empty_w[3], ae_w[3]}); end
        default: if ({vout_w[3], dout_w[3]} !== {1'b1, 8'h77}) begin n_fail++; $display("[TB] FAIL lane3_pop77 dataout got %b/%h exp 1/77", vout_w[3], dout_w[3]); end
      endcase
    end
  endtask

  task automatic test_mid_reset();
    for (int s = 0; s < 6; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      for (int l = 0; l < 4; l++) begin
        if (s < 2) begin v_in[l] = 1'b1; d_in[l] = 8'($urandom); end
        if (s == 2) begin rst = 1'b1; v_in[l] = 1'b1; p_in[l] = 1'b1; d_in[l] = 8'($urandom); end
        if (s == 4) begin v_in[l] = 1'b1; d_in[l] = 8'(8'hC0 + l); end
        if (s == 5) p_in[l] = 1'b1;
      end
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL mid_reset lane%0d valid_out got %b exp %b", l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL mid_reset lane%0d dataout got %h exp %h", l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL mid_reset lane%0d flags(full,empty,af,ae) got %b exp %b", l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL mid_reset lane%0d error got %b exp %b", l, err_w[l], m_err[l]); end
        if (s == 2) begin
          n_chk++;
          if ({empty_w[l], err_w[l], vout_w[l]} !== 3'b100) begin n_fail++; $display("[TB] FAIL mid_reset_clear lane%0d {empty,err,vout} got %b exp 100", l, {empty_w[l], err_w[l], vout_w[l]}); end
        end
        if (s == 5) begin
          n_chk++;
          if (dout_w[l] !== 8'(8'hC0 + l)) begin n_fail++; $display("[TB] FAIL mid_reset_newdata lane%0d dataout got %h exp %h", l, dout_w[l], 8'(8'hC0 + l)); end
        end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL mid_reset pause got %b exp %b", pause_w, ep); end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      bit ep = 1'b0;
      clear_inputs();
      rst = ($urandom_range(0, 79) == 0);
      for (int l = 0; l < 4; l++) begin
        v_in[l] = ($urandom_range(0, 99) < 55);
        p_in[l] = ($urandom_range(0, 99) < 45);
        d_in[l] = 8'($urandom);
      end
      tick();
      for (int l = 0; l < 4; l++) begin
        int n = q[l].size();
        logic [3:0] ef = {n == 4, n == 0, n >= 3, n <= 1};
        logic [3:0] gf = {full_w[l], empty_w[l], af_w[l], ae_w[l]};
        if (n >= 3) ep = 1'b1;
        n_chk += 4;
        if (vout_w[l] !== m_vout[l]) begin n_fail++; $display("[TB] FAIL random%0d lane%0d valid_out got %b exp %b", s, l, vout_w[l], m_vout[l]); end
        if (dout_w[l] !== m_dout[l]) begin n_fail++; $display("[TB] FAIL random%0d lane%0d dataout got %h exp %h", s, l, dout_w[l], m_dout[l]); end
        if (gf !== ef) begin n_fail++; $display("[TB] FAIL random%0d lane%0d flags(full,empty,af,ae) got %b exp %b", s, l, gf, ef); end
        if (err_w[l] !== m_err[l]) begin n_fail++; $display("[TB] FAIL random%0d lane%0d error got %b exp %b", s, l, err_w[l], m_err[l]); end
      end
      n_chk++;
      if (pause_w !== ep) begin n_fail++; $display("[TB] FAIL random%0d pause got %b exp %b", s, pause_w, ep); end
    end
  endtask

  initial begin
    clear_inputs();
    for (int l = 0; l < 4; l++) begin
      m_dout[l] = 8'h00;
      m_vout[l] = 1'b0;
      m_err[l]  = 1'b0;
    end
    test_reset();
    test_lane0_order();
    test_lane1_overflow();
    test_back_to_back();
    test_lane3_underflow();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
